// File: rtl/bsg_fifo_1r1w_2el_ctrl_width_p131_if.sv
// Producer/consumer handshake bundle for the two-entry FIFO controller.
// The master modport is the traffic side; the slave modport is the controller.
interface bsg_fifo_1r1w_2el_ctrl_width_p131_if #(parameter int width_p = 131);
  logic               v_i;
  logic [width_p-1:0] data_i;
  logic               ready_o;
  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               yumi_i;

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o
  );

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o
  );
endinterface

// File: rtl/bsg_fifo_1r1w_2el_ctrl_width_p131.sv
// Two-entry ready/valid queue controller driving an external 2x131 1r1w memory.
// Owns pointers, occupancy and the sticky illegal-yumi flag.
module bsg_fifo_1r1w_2el_ctrl_width_p131 #(
  parameter int width_p = 131,
  parameter int els_p   = 2
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  bsg_fifo_1r1w_2el_ctrl_width_p131_if.slave fifo,
  output logic                mem_w_v_o,
  output logic                mem_w_addr_o,
  output logic [width_p-1:0]  mem_w_data_o,
  output logic                mem_r_v_o,
  output logic                mem_r_addr_o,
  input  logic [width_p-1:0]  mem_r_data_i,
  output logic [1:0]          count_o,
  output logic                err_o
);

  logic       wptr;
  logic       rptr;
  logic [1:0] count;
  logic       err;
  logic       ready;
  logic       valid;
  logic       enq;
  logic       deq;

  // Handshake flags come only from registered count, never from v_i/yumi_i.
  assign ready = (count != 2'd2);
  assign valid = (count != 2'd0);
  assign enq   = fifo.v_i & ready;
  assign deq   = fifo.yumi_i & valid;

  assign fifo.ready_o = ready;
  assign fifo.v_o     = valid;
  assign fifo.data_o  = valid ? mem_r_data_i : '0;

  assign mem_w_v_o    = enq;
  assign mem_w_addr_o = wptr;
  assign mem_w_data_o = fifo.data_i;
  assign mem_r_v_o    = valid;
  assign mem_r_addr_o = rptr;

  assign count_o = count;
  assign err_o   = err;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
      err   <= 1'b0;
    end else begin
      if (enq) wptr <= ~wptr;
      if (deq) rptr <= ~rptr;
      count <= count + {1'b0, enq} - {1'b0, deq};
      // An illegal yumi only flags; pointers and count ignore it via deq.
      if (fifo.yumi_i & ~valid) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_fifo_1r1w_2el_ctrl_width_p131.sv
// Directed bench for the two-entry FIFO controller with a behavioural 2x131 memory.
module tb_bsg_fifo_1r1w_2el_ctrl_width_p131;
  localparam int W = 131;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         mem_w_v_o;
  logic         mem_w_addr_o;
  logic [W-1:0] mem_w_data_o;
  logic         mem_r_v_o;
  logic         mem_r_addr_o;
  logic [W-1:0] mem_r_data_i;
  logic [1:0]   count_o;
  logic         err_o;

  logic [W-1:0] mem [2];

  int checks = 0;
  int errors = 0;

  bsg_fifo_1r1w_2el_ctrl_width_p131_if #(.width_p(W)) fifo ();

  bsg_fifo_1r1w_2el_ctrl_width_p131 #(.width_p(W), .els_p(2)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .fifo         (fifo.slave),
    .mem_w_v_o    (mem_w_v_o),
    .mem_w_addr_o (mem_w_addr_o),
    .mem_w_data_o (mem_w_data_o),
    .mem_r_v_o    (mem_r_v_o),
    .mem_r_addr_o (mem_r_addr_o),
    .mem_r_data_i (mem_r_data_i),
    .count_o      (count_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (mem_w_v_o) mem[mem_w_addr_o] <= mem_w_data_o;
  assign mem_r_data_i = mem[mem_r_addr_o];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic y);
    fifo.v_i    = v;
    fifo.data_i = d;
    fifo.yumi_i = y;
    #1;
  endtask

  logic [W-1:0] pat_a;
  logic [W-1:0] pat_b;

  initial begin
    pat_a = {3'b001, {32{4'hA}}};
    pat_b = {3'b010, {32{4'h5}}};
    reset_n_i   = 1'b0;
    fifo.v_i    = 1'b0;
    fifo.data_i = '0;
    fifo.yumi_i = 1'b0;

    // reset held mid-cycle
    #3;
    chk("rst_ready", W'(fifo.ready_o), 1);
    chk("rst_v", W'(fifo.v_o), 0);
    chk("rst_count", W'(count_o), 0);
    chk("rst_data", fifo.data_o, 0);
    chk("rst_err", W'(err_o), 0);
    chk("rst_mem_w_v", W'(mem_w_v_o), 0);
    chk("rst_mem_r_v", W'(mem_r_v_o), 0);
    #9 reset_n_i = 1'b1;
    tick();
    chk("idle_ready", W'(fifo.ready_o), 1);
    chk("idle_v", W'(fifo.v_o), 0);
    chk("idle_count", W'(count_o), 0);
    chk("idle_data", fifo.data_o, 0);

    // fill and drain
    drive(1, pat_a, 0);
    chk("fill0_wv", W'(mem_w_v_o), 1);
    chk("fill0_waddr", W'(mem_w_addr_o), 0);
    chk("fill0_wdata", mem_w_data_o, pat_a);
    tick();
    chk("fill0_count", W'(count_o), 1);
    chk("fill0_v", W'(fifo.v_o), 1);
    chk("fill0_data", fifo.data_o, pat_a);
    drive(1, pat_b, 0);
    chk("fill1_waddr", W'(mem_w_addr_o), 1);
    tick();
    chk("fill1_count", W'(count_o), 2);
    chk("fill1_ready", W'(fifo.ready_o), 0);
    drive(0, '0, 1);
    chk("drain0_data", fifo.data_o, pat_a);
    tick();
    chk("drain1_data", fifo.data_o, pat_b);
    chk("drain1_count", W'(count_o), 1);
    tick();
    chk("drain_count", W'(count_o), 0);
    chk("drain_v", W'(fifo.v_o), 0);
    chk("drain_data", fifo.data_o, 0);

    // full with simultaneous v_i and yumi_i
    drive(1, pat_a, 0); tick();
    drive(1, pat_b, 0); tick();
    drive(1, W'(3), 1);
    chk("full_no_write", W'(mem_w_v_o), 0);
    tick();
    chk("full_pop_count", W'(count_o), 1);
    chk("full_pop_head", fifo.data_o, pat_b);
    drive(1, W'(3), 0);
    chk("full_retry_wv", W'(mem_w_v_o), 1);
    tick();
    chk("full_retry_count", W'(count_o), 2);
    drive(0, '0, 1); tick();
    chk("pre_stream_count", W'(count_o), 1);
    chk("pre_stream_head", fifo.data_o, W'(3));

    // streaming at count 1 with wrapping pointers
    for (int i = 0; i < 20; i++) begin
      drive(1, W'(100 + i), 1);
      chk("stream_head", fifo.data_o, (i == 0) ? W'(3) : W'(100 + i - 1));
      chk("stream_same_addr", W'(mem_r_addr_o != mem_w_addr_o), 1);
      tick();
      chk("stream_count", W'(count_o), 1);
    end
    drive(0, '0, 1);
    chk("stream_last", fifo.data_o, W'(119));
    tick();
    chk("stream_end_count", W'(count_o), 0);

    // illegal yumi on empty
    drive(0, '0, 1);
    chk("illegal_err_before", W'(err_o), 0);
    tick();
    chk("illegal_err", W'(err_o), 1);
    chk("illegal_count", W'(count_o), 0);
    chk("illegal_v", W'(fifo.v_o), 0);
    drive(1, W'(7), 0); tick();
    chk("sticky_err0", W'(err_o), 1);
    chk("sticky_head7", fifo.data_o, W'(7));
    drive(1, W'(8), 1); tick();
    chk("sticky_err1", W'(err_o), 1);
    chk("sticky_head8", fifo.data_o, W'(8));
    drive(1, W'(9), 0); tick();
    chk("pre_rst_count", W'(count_o), 2);
    chk("pre_rst_err", W'(err_o), 1);
    drive(0, '0, 0);

    // reset mid-operation, between edges
    reset_n_i = 1'b0;
    #1;
    chk("midrst_v", W'(fifo.v_o), 0);
    chk("midrst_count", W'(count_o), 0);
    chk("midrst_err", W'(err_o), 0);
    chk("midrst_data", fifo.data_o, 0);
    #1 reset_n_i = 1'b1;
    drive(1, W'(12), 0);
    chk("post_rst_waddr", W'(mem_w_addr_o), 0);
    tick();
    drive(0, '0, 0);
    chk("post_rst_data", fifo.data_o, W'(12));
    chk("post_rst_count", W'(count_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
